fetch_pipe_ctrl: RTL and testbench

- Receiving end of the hazard unit's stall/flush interface. Owns the PC register, the IF/ID pipeline register and the ID/EX valid bit.
- Applies stall, flush and branch-redirect commands with fixed priority. Supplies the fetch address to instruction memory, which is asynchronous-read.
- Keeps saturating stall and flush event counters and a stall-watchdog flag for debug and performance.

---
 rtl/fetch_pipe_ctrl_if.sv | 38 +++
 rtl/fetch_pipe_ctrl.sv | 152 +++++++++++++++
 tb/tb_fetch_pipe_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pipe_ctrl_if.sv
// Hazard-unit command bus into the fetch controller, plus the controller's
// fetch/IF-ID/debug outputs. The hazard unit (or a bench) is the master and
// drives the commands; fetch_pipe_ctrl is the slave.
interface fetch_pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             i_stall_pc;
    logic             i_stall_if_id;
    logic             i_flush_if_id;
    logic             i_flush_id_ex;
    logic             i_branch_taken;
    logic [31:0]      i_branch_target;
    logic [31:0]      i_imem_instr;
    logic             i_counter_clr;
    logic [31:0]      o_pc;
    logic [31:0]      o_if_id_pc;
    logic [31:0]      o_if_id_instr;
    logic             o_if_id_valid;
    logic             o_id_ex_valid;
    logic             o_misalign;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;
    logic             o_stall_timeout;

    modport master (
        output i_stall_pc, i_stall_if_id, i_flush_if_id, i_flush_id_ex,
               i_branch_taken, i_branch_target, i_imem_instr, i_counter_clr,
        input  o_pc, o_if_id_pc, o_if_id_instr, o_if_id_valid, o_id_ex_valid,
               o_misalign, o_stall_cnt, o_flush_cnt, o_stall_timeout
    );

    modport slave (
        input  i_stall_pc, i_stall_if_id, i_flush_if_id, i_flush_id_ex,
               i_branch_taken, i_branch_target, i_imem_instr, i_counter_clr,
        output o_pc, o_if_id_pc, o_if_id_instr, o_if_id_valid, o_id_ex_valid,
               o_misalign, o_stall_cnt, o_flush_cnt, o_stall_timeout
    );
endinterface

// File: rtl/fetch_pipe_ctrl.sv
// Fetch pipeline controller: owns the PC, the IF/ID register and the ID/EX
// valid bit, applying redirect/stall/flush commands with fixed priority.
// Also keeps saturating stall/flush event counters and a sticky watchdog
// that trips after MAX_STALL consecutive PC stall cycles.
// The interface instance must be built with the same CNT_W as this module.
module fetch_pipe_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16,
    parameter int          MAX_STALL = 64
) (
    input  logic               i_clk,
    input  logic               i_reset,
    fetch_pipe_ctrl_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(MAX_STALL);

    logic [31:0]      pc_r,          pc_next_s;
    logic [31:0]      if_id_pc_r,    if_id_pc_next_s;
    logic [31:0]      if_id_instr_r, if_id_instr_next_s;
    logic             if_id_valid_r, if_id_valid_next_s;
    logic             id_ex_valid_r, id_ex_valid_next_s;
    logic             misalign_r,    misalign_next_s;
    logic [CNT_W-1:0] stall_cnt_r,   stall_cnt_next_s;
    logic [CNT_W-1:0] flush_cnt_r,   flush_cnt_next_s;
    logic [CNT_W-1:0] run_len_r,     run_len_next_s;
    logic             timeout_r,     timeout_next_s;
    logic             stall_qual_s;

    // Next-state for PC, IF/ID and ID/EX valid following the command priorities.
    always_comb begin
        pc_next_s          = pc_r;
        if_id_pc_next_s    = if_id_pc_r;
        if_id_instr_next_s = if_id_instr_r;
        if_id_valid_next_s = if_id_valid_r;
        misalign_next_s    = 1'b0;

        // A redirect wins over a PC stall; the target is forced word-aligned.
        if (bus.i_branch_taken) begin
            pc_next_s       = {bus.i_branch_target[31:2], 2'b00};
            misalign_next_s = |bus.i_branch_target[1:0];
        end else if (bus.i_stall_pc) begin
            pc_next_s = pc_r;
        end else begin
            pc_next_s = pc_r + 32'd4;
        end

        // A flush wins over an IF/ID stall and leaves a NOP bubble.
        if (bus.i_flush_if_id) begin
            if_id_pc_next_s    = 32'h0000_0000;
            if_id_instr_next_s = NOP_INSTR;
            if_id_valid_next_s = 1'b0;
        end else if (bus.i_stall_if_id) begin
            if_id_pc_next_s    = if_id_pc_r;
            if_id_instr_next_s = if_id_instr_r;
            if_id_valid_next_s = if_id_valid_r;
        end else begin
            if_id_pc_next_s    = pc_r;
            if_id_instr_next_s = bus.i_imem_instr;
            if_id_valid_next_s = 1'b1;
        end

        if (bus.i_flush_id_ex) begin
            id_ex_valid_next_s = 1'b0;
        end else begin
            id_ex_valid_next_s = if_id_valid_r;
        end
    end

    // Next-state for the event counters, stall run-length and watchdog flag.
    always_comb begin
        stall_qual_s     = bus.i_stall_pc & ~bus.i_branch_taken;
        stall_cnt_next_s = stall_cnt_r;
        flush_cnt_next_s = flush_cnt_r;
        run_len_next_s   = CNT_ZERO;

        if (bus.i_counter_clr) begin
            stall_cnt_next_s = CNT_ZERO;
        end else if (stall_qual_s && (stall_cnt_r != CNT_SAT)) begin
            stall_cnt_next_s = stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_next_s = stall_cnt_r;
        end

        if (bus.i_counter_clr) begin
            flush_cnt_next_s = CNT_ZERO;
        end else if (bus.i_flush_if_id && (flush_cnt_r != CNT_SAT)) begin
            flush_cnt_next_s = flush_cnt_r + CNT_ONE;
        end else begin
            flush_cnt_next_s = flush_cnt_r;
        end

        // Run-length saturates at MAX_STALL and restarts on any non-stall cycle.
        if (!stall_qual_s) begin
            run_len_next_s = CNT_ZERO;
        end else if (run_len_r == RUN_MAX) begin
            run_len_next_s = run_len_r;
        end else begin
            run_len_next_s = run_len_r + CNT_ONE;
        end

        // Sticky: the flag is visible from the cycle after the run reaches MAX_STALL.
        timeout_next_s = timeout_r | (run_len_next_s == RUN_MAX);
    end

    // Pipeline state registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc_r          <= RESET_PC;
            if_id_pc_r    <= 32'h0000_0000;
            if_id_instr_r <= NOP_INSTR;
            if_id_valid_r <= 1'b0;
            id_ex_valid_r <= 1'b0;
            misalign_r    <= 1'b0;
        end else begin
            pc_r          <= pc_next_s;
            if_id_pc_r    <= if_id_pc_next_s;
            if_id_instr_r <= if_id_instr_next_s;
            if_id_valid_r <= if_id_valid_next_s;
            id_ex_valid_r <= id_ex_valid_next_s;
            misalign_r    <= misalign_next_s;
        end
    end

    // Debug/performance registers; only i_reset clears the watchdog flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stall_cnt_r <= CNT_ZERO;
            flush_cnt_r <= CNT_ZERO;
            run_len_r   <= CNT_ZERO;
            timeout_r   <= 1'b0;
        end else begin
            stall_cnt_r <= stall_cnt_next_s;
            flush_cnt_r <= flush_cnt_next_s;
            run_len_r   <= run_len_next_s;
            timeout_r   <= timeout_next_s;
        end
    end

    assign bus.o_pc            = pc_r;
    assign bus.o_if_id_pc      = if_id_pc_r;
    assign bus.o_if_id_instr   = if_id_instr_r;
    assign bus.o_if_id_valid   = if_id_valid_r;
    assign bus.o_id_ex_valid   = id_ex_valid_r;
    assign bus.o_misalign      = misalign_r;
    assign bus.o_stall_cnt     = stall_cnt_r;
    assign bus.o_flush_cnt     = flush_cnt_r;
    assign bus.o_stall_timeout = timeout_r;
endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Self-checking bench for fetch_pipe_ctrl: directed scenarios from the
// intended behaviour, then randomized commands, all compared against a
// cycle-level behavioural model built from the priority rules.
module tb_fetch_pipe_ctrl;
    localparam int          CW        = 4;
    localparam int          MAXS      = 4;
    localparam int          SAT       = (1 << CW) - 1;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] RST_PC    = 32'h0000_0000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fetch_pipe_ctrl_if #(.CNT_W(CW)) bus ();

    fetch_pipe_ctrl #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP),
        .CNT_W    (CW),
        .MAX_STALL(MAXS)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    // Behavioural model state.
    logic [31:0] m_pc, m_ifid_pc, m_ifid_instr;
    bit          m_ifid_valid, m_idex_valid, m_mis, m_to;
    int          m_scnt, m_fcnt, m_run;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_ifid_pc = 32'h0; m_ifid_instr = NOP;
        m_ifid_valid = 0; m_idex_valid = 0; m_mis = 0; m_to = 0;
        m_scnt = 0; m_fcnt = 0; m_run = 0;
    endtask

    // One clock of the architectural rules, using the commands presented this cycle.
    task automatic model_update();
        bit stall_cycle;
        logic [31:0] old_pc;
        stall_cycle = bus.i_stall_pc && !bus.i_branch_taken;
        old_pc = m_pc;
        m_idex_valid = bus.i_flush_id_ex ? 0 : m_ifid_valid;
        if (bus.i_flush_if_id) begin
            m_ifid_pc = 0; m_ifid_instr = NOP; m_ifid_valid = 0;
        end else if (!bus.i_stall_if_id) begin
            m_ifid_pc = old_pc; m_ifid_instr = bus.i_imem_instr; m_ifid_valid = 1;
        end
        if (bus.i_branch_taken) m_pc = bus.i_branch_target & 32'hFFFF_FFFC;
        else if (!bus.i_stall_pc) m_pc = old_pc + 32'd4;
        m_mis = bus.i_branch_taken && (bus.i_branch_target % 4 != 0);
        if (bus.i_counter_clr) m_scnt = 0;
        else if (stall_cycle) m_scnt = (m_scnt + 1 > SAT) ? SAT : m_scnt + 1;
        if (bus.i_counter_clr) m_fcnt = 0;
        else if (bus.i_flush_if_id) m_fcnt = (m_fcnt + 1 > SAT) ? SAT : m_fcnt + 1;
        m_run = stall_cycle ? ((m_run + 1 > MAXS) ? MAXS : m_run + 1) : 0;
        if (m_run == MAXS) m_to = 1;
    endtask

    task automatic check_all();
        check_eq("pc",          bus.o_pc,                  m_pc);
        check_eq("if_id_pc",    bus.o_if_id_pc,            m_ifid_pc);
        check_eq("if_id_instr", bus.o_if_id_instr,         m_ifid_instr);
        check_eq("if_id_valid", 32'(bus.o_if_id_valid),    32'(m_ifid_valid));
        check_eq("id_ex_valid", 32'(bus.o_id_ex_valid),    32'(m_idex_valid));
        check_eq("misalign",    32'(bus.o_misalign),       32'(m_mis));
        check_eq("stall_cnt",   32'(bus.o_stall_cnt),      32'(m_scnt));
        check_eq("flush_cnt",   32'(bus.o_flush_cnt),      32'(m_fcnt));
        check_eq("timeout",     32'(bus.o_stall_timeout),  32'(m_to));
    endtask

    task automatic drive_idle();
        bus.i_stall_pc = 0; bus.i_stall_if_id = 0; bus.i_flush_if_id = 0;
        bus.i_flush_id_ex = 0; bus.i_branch_taken = 0; bus.i_branch_target = 32'h0;
        bus.i_counter_clr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic apply_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drive_idle();
        bus.i_imem_instr = 32'h00A0_0093;
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        rst = 1'b0;

        // Straight-line fetch after reset.
        step();
        check_eq("tp1_pc1", bus.o_pc, 32'h4);
        check_eq("tp1_ifid_pc1", bus.o_if_id_pc, 32'h0);
        check_eq("tp1_ifid_v1", 32'(bus.o_if_id_valid), 32'h1);
        step();
        check_eq("tp1_pc2", bus.o_pc, 32'h8);
        check_eq("tp1_ifid_pc2", bus.o_if_id_pc, 32'h4);
        check_eq("tp1_idex_v2", 32'(bus.o_id_ex_valid), 32'h1);

        // Two-cycle data stall at PC=8.
        bus.i_stall_pc = 1; bus.i_stall_if_id = 1; bus.i_flush_id_ex = 1;
        step();
        step();
        check_eq("tp2_pc", bus.o_pc, 32'h8);
        check_eq("tp2_ifid_pc", bus.o_if_id_pc, 32'h4);
        check_eq("tp2_idex_v", 32'(bus.o_id_ex_valid), 32'h0);
        check_eq("tp2_stall_cnt", 32'(bus.o_stall_cnt), 32'h2);
        drive_idle();
        step();
        check_eq("tp2_pc_resume", bus.o_pc, 32'hC);
        check_eq("tp2_idex_resume", 32'(bus.o_id_ex_valid), 32'h1);

        // Redirect beats a simultaneous stall.
        bus.i_branch_taken = 1; bus.i_branch_target = 32'h100; bus.i_flush_if_id = 1;
        bus.i_flush_id_ex = 1; bus.i_stall_pc = 1;
        step();
        check_eq("tp3_pc", bus.o_pc, 32'h100);
        check_eq("tp3_instr", bus.o_if_id_instr, NOP);
        check_eq("tp3_valid", 32'(bus.o_if_id_valid), 32'h0);
        check_eq("tp3_flush_cnt", 32'(bus.o_flush_cnt), 32'h1);
        check_eq("tp3_stall_cnt", 32'(bus.o_stall_cnt), 32'h2);

        // Misaligned redirect target.
        drive_idle();
        bus.i_branch_taken = 1; bus.i_branch_target = 32'h0000_0102;
        step();
        check_eq("tp4_pc", bus.o_pc, 32'h100);
        check_eq("tp4_mis", 32'(bus.o_misalign), 32'h1);
        drive_idle();
        step();
        check_eq("tp4_mis_drop", 32'(bus.o_misalign), 32'h0);

        // Watchdog: run of 3, gap, run of 4.
        apply_reset();
        bus.i_stall_pc = 1;
        for (int i = 0; i < 3; i++) step();
        check_eq("tp5_to_run1", 32'(bus.o_stall_timeout), 32'h0);
        bus.i_stall_pc = 0;
        step();
        bus.i_stall_pc = 1;
        for (int i = 0; i < 3; i++) step();
        check_eq("tp5_to_run2_3", 32'(bus.o_stall_timeout), 32'h0);
        step();
        check_eq("tp5_to_run2_4", 32'(bus.o_stall_timeout), 32'h1);
        bus.i_stall_pc = 0; bus.i_counter_clr = 1;
        step();
        check_eq("tp5_to_after_clr", 32'(bus.o_stall_timeout), 32'h1);
        check_eq("tp5_scnt_clr", 32'(bus.o_stall_cnt), 32'h0);
        bus.i_counter_clr = 0;
        apply_reset();
        check_eq("tp5_to_reset", 32'(bus.o_stall_timeout), 32'h0);

        // Flush counter saturation and clear priority.
        bus.i_flush_if_id = 1;
        for (int i = 0; i < 20; i++) step();
        check_eq("tp6_fcnt_sat", 32'(bus.o_flush_cnt), 32'(SAT));
        bus.i_counter_clr = 1;
        step();
        check_eq("tp6_fcnt_clr", 32'(bus.o_flush_cnt), 32'h0);
        bus.i_counter_clr = 0;
        step();
        check_eq("tp6_fcnt_one", 32'(bus.o_flush_cnt), 32'h1);
        drive_idle();

        // Randomized commands against the model, with occasional async resets.
        for (int c = 0; c < 3000; c++) begin
            bus.i_stall_pc      = ($urandom_range(0, 99) < 45);
            bus.i_stall_if_id   = ($urandom_range(0, 99) < 80) ? bus.i_stall_pc
                                                                : 1'($urandom_range(0, 1));
            bus.i_flush_if_id   = ($urandom_range(0, 99) < 15);
            bus.i_flush_id_ex   = ($urandom_range(0, 99) < 15);
            bus.i_branch_taken  = ($urandom_range(0, 99) < 10);
            bus.i_branch_target = $urandom;
            bus.i_imem_instr    = $urandom;
            bus.i_counter_clr   = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 199) == 0) begin
                apply_reset();
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
